// File: rtl/ahb_split_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg : shared AHB encodings for the SPLIT controller        | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

  localparam int HMASTER_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPLIT1 = 2'd1,
    ST_SPLIT2 = 2'd2,
    ST_WAIT   = 2'd3
  } split_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_split_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_split_ctrl_if : AHB slave-side signals seen by the SPLIT controller | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ahb_split_ctrl_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16
);
  logic                   HSEL;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [HMASTER_W-1:0]   HMASTER;
  logic                   HMASTLOCK;
  logic                   HREADYOUT;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HSPLITx;

  modport slave (
    input  HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK,
    output HREADYOUT, HRESP, HSPLITx
  );

  modport master (
    output HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK,
    input  HREADYOUT, HRESP, HSPLITx
  );
endinterface

`default_nettype wire

// File: rtl/ahb_split_ctrl_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick : combinational round-robin picker, first request at/after ptr | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [HMASTER_W-1:0]   ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   valid
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_MASTERS);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_split_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_split_ctrl : SPLIT response generator and round-robin HSPLITx release | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_split_ctrl
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16,
  parameter int RELEASE_GAP = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_split_ctrl_if.slave        bus,
  input  logic                   busy_i,
  output logic                   accept_o,
  output logic [NUM_MASTERS-1:0] pending_o
);

  localparam logic [3:0]             GAP_LOAD = 4'(RELEASE_GAP);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  split_state_t           state_q, state_d;
  logic [NUM_MASTERS-1:0] pending_q, pending_d;
  logic [NUM_MASTERS-1:0] hsplit_q, hsplit_d;
  logic [HMASTER_W-1:0]   ptr_q, ptr_d;
  logic [3:0]             gap_q, gap_d;
  logic                   accept_q, accept_d;

  logic                   vap;
  logic                   wait_done;
  logic                   hreadyout;
  hresp_t                 hresp;
  logic [NUM_MASTERS-1:0] set_vec;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   pick_valid;
  logic                   release_go;
  logic [HMASTER_W-1:0]   sel_idx;

  assign vap = bus.HSEL && bus.HREADY &&
               ((htrans_t'(bus.HTRANS) == HTRANS_NONSEQ) ||
                (htrans_t'(bus.HTRANS) == HTRANS_SEQ));

  always_comb begin
    state_d   = state_q;
    set_vec   = '0;
    accept_d  = 1'b0;
    wait_done = 1'b0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      ST_IDLE: begin
        if (vap) begin
          if (!busy_i) begin
            accept_d = 1'b1;
          end else if (!bus.HMASTLOCK) begin
            set_vec = ONE_HOT0 << bus.HMASTER;
            state_d = ST_SPLIT1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_SPLIT1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_SPLIT;
        state_d   = ST_SPLIT2;
      end
      ST_SPLIT2: begin
        hresp   = HRESP_SPLIT;
        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        // Locked transfers are stalled, never split, until the resource frees.
        if (busy_i) begin
          hreadyout = 1'b0;
        end else begin
          wait_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The master currently pulsed is excluded so a zero gap cannot re-pick it.
  assign req = pending_q & ~hsplit_q;

  ahb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .valid (pick_valid)
  );

  assign release_go = (state_q == ST_IDLE) && !busy_i && (gap_q == 4'd0) && pick_valid;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_idx = HMASTER_W'(i);
      end
    end
  end

  always_comb begin
    hsplit_d = release_go ? gnt : '0;
    // Pending bit is cleared in the pulse cycle; a fresh split that cycle wins.
    pending_d = (pending_q & ~hsplit_q) | set_vec;
    ptr_d     = ptr_q;
    if (release_go) begin
      ptr_d = (int'(sel_idx) == NUM_MASTERS - 1) ? '0 : sel_idx + HMASTER_W'(1);
    end
    if (release_go) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = 4'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      hsplit_q  <= '0;
      ptr_q     <= '0;
      gap_q     <= 4'd0;
      accept_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hsplit_q  <= hsplit_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      accept_q  <= accept_d;
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HSPLITx   = hsplit_q & ~set_vec;
  assign accept_o      = accept_q | wait_done;
  assign pending_o     = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_split_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_split_ctrl : directed self-checking bench for ahb_split_ctrl | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_split_ctrl;
  import ahb_pkg::*;

  localparam int NM = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy  = 1'b0;
  logic          accept;
  logic [NM-1:0] pending;
  int            errors = 0;
  int            checks = 0;

  ahb_split_ctrl_if #(.NUM_MASTERS(NM)) bus_if ();

  ahb_split_ctrl #(
    .NUM_MASTERS (NM),
    .RELEASE_GAP (2)
  ) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .bus       (bus_if.slave),
    .busy_i    (busy),
    .accept_o  (accept),
    .pending_o (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vap(input logic [3:0] m, input logic lock);
    bus_if.HSEL      = 1'b1;
    bus_if.HTRANS    = 2'd2;
    bus_if.HREADY    = 1'b1;
    bus_if.HMASTER   = m;
    bus_if.HMASTLOCK = lock;
  endtask

  task automatic drive_idle();
    bus_if.HSEL      = 1'b0;
    bus_if.HTRANS    = 2'd0;
    bus_if.HREADY    = 1'b1;
    bus_if.HMASTER   = 4'd0;
    bus_if.HMASTLOCK = 1'b0;
  endtask

  // Full split of master m while busy; returns in the following IDLE cycle.
  task automatic do_split(input logic [3:0] m);
    busy = 1'b1;
    drive_vap(m, 1'b0);
    tick();
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    busy = 1'b0;
    #12;
    checks++; if (bus_if.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got=%b exp=1", bus_if.HREADYOUT); end
    checks++; if (bus_if.HRESP !== 2'd0) begin errors++; $display("FAIL reset_hresp got=%0d exp=0", bus_if.HRESP); end
    checks++; if (bus_if.HSPLITx !== 16'h0) begin errors++; $display("FAIL reset_hsplit got=%h exp=0000", bus_if.HSPLITx); end
    checks++; if (accept !== 1'b0) begin errors++; $display("FAIL reset_accept got=%b exp=0", accept); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending got=%h exp=0000", pending); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accept();
    busy = 1'b0;
    drive_vap(4'd3, 1'b0);
    #1;
    checks++; if (bus_if.HRESP !== 2'd0) begin errors++; $display("FAIL accept_hresp got=%0d exp=0", bus_if.HRESP); end
    checks++; if (bus_if.HREADYOUT !== 1'b1) begin errors++; $display("FAIL accept_hready got=%b exp=1", bus_if.HREADYOUT); end
    tick();
    drive_idle();
    #1;
    checks++; if (accept !== 1'b1) begin errors++; $display("FAIL accept_pulse got=%b exp=1", accept); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL accept_pending got=%h exp=0000", pending); end
    tick();
    #1;
    checks++; if (accept !== 1'b0) begin errors++; $display("FAIL accept_single got=%b exp=0", accept); end
  endtask

  task automatic test_split_release();
    busy = 1'b1;
    drive_vap(4'd5, 1'b0);
    tick();
    drive_idle();
    #1;
    checks++; if ({bus_if.HREADYOUT, bus_if.HRESP} !== 3'b011) begin errors++; $display("FAIL split1_resp got=%b exp=011", {bus_if.HREADYOUT, bus_if.HRESP}); end
    tick();
    #1;
    checks++; if ({bus_if.HREADYOUT, bus_if.HRESP} !== 3'b111) begin errors++; $display("FAIL split2_resp got=%b exp=111", {bus_if.HREADYOUT, bus_if.HRESP}); end
    checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL split_pending got=%h exp=0020", pending); end
    tick();
    busy = 1'b0;
    #1;
    checks++; if (bus_if.HSPLITx !== 16'h0) begin errors++; $display("FAIL release_early got=%h exp=0000", bus_if.HSPLITx); end
    tick();
    #1;
    checks++; if (bus_if.HSPLITx !== 16'h0020) begin errors++; $display("FAIL release_pulse got=%h exp=0020", bus_if.HSPLITx); end
    tick();
    #1;
    checks++; if (bus_if.HSPLITx !== 16'h0) begin errors++; $display("FAIL release_width got=%h exp=0000", bus_if.HSPLITx); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL release_pending got=%h exp=0000", pending); end
  endtask

  task automatic test_rr_order();
    logic [NM-1:0] first;
    logic [NM-1:0] pulses [3];
    int            at [3];
    int            n;
    logic [NM-1:0] e0, e1, e2;
    e0 = 16'h1 << 14;
    e1 = 16'h1 << 2;
    e2 = 16'h1 << 9;
    // Release master 9 alone so the pointer lands on 10.
    busy = 1'b1;
    repeat (3) tick();
    do_split(4'd9);
    busy  = 1'b0;
    first = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus_if.HSPLITx !== 16'h0 && first === 16'h0) first = bus_if.HSPLITx;
      tick();
    end
    checks++; if (first !== 16'h0200) begin errors++; $display("FAIL rr_setup got=%h exp=0200", first); end
    do_split(4'd2);
    do_split(4'd9);
    do_split(4'd14);
    #1;
    checks++; if (pending !== 16'h4204) begin errors++; $display("FAIL rr_pending got=%h exp=4204", pending); end
    busy = 1'b0;
    n    = 0;
    for (int i = 0; i < 3; i++) begin pulses[i] = '0; at[i] = 0; end
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus_if.HSPLITx !== 16'h0) begin
        if (n < 3) begin pulses[n] = bus_if.HSPLITx; at[n] = c; end
        n++;
      end
      tick();
    end
    checks++; if (n != 3) begin errors++; $display("FAIL rr_count got=%0d exp=3", n); end
    checks++; if (pulses[0] !== e0) begin errors++; $display("FAIL rr_first got=%h exp=%h", pulses[0], e0); end
    checks++; if (pulses[1] !== e1) begin errors++; $display("FAIL rr_second got=%h exp=%h", pulses[1], e1); end
    checks++; if (pulses[2] !== e2) begin errors++; $display("FAIL rr_third got=%h exp=%h", pulses[2], e2); end
    checks++; if (at[1] - at[0] != 3) begin errors++; $display("FAIL rr_gap01 got=%0d exp=3", at[1] - at[0]); end
    checks++; if (at[2] - at[1] != 3) begin errors++; $display("FAIL rr_gap12 got=%0d exp=3", at[2] - at[1]); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL rr_drained got=%h exp=0000", pending); end
  endtask

  task automatic test_locked();
    busy = 1'b1;
    drive_vap(4'd7, 1'b1);
    tick();
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({bus_if.HREADYOUT, bus_if.HRESP} !== 3'b000) begin errors++; $display("FAIL lock_wait%0d got=%b exp=000", c, {bus_if.HREADYOUT, bus_if.HRESP}); end
      tick();
    end
    busy = 1'b0;
    #1;
    checks++; if (bus_if.HREADYOUT !== 1'b1) begin errors++; $display("FAIL lock_ready got=%b exp=1", bus_if.HREADYOUT); end
    checks++; if (accept !== 1'b1) begin errors++; $display("FAIL lock_accept got=%b exp=1", accept); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL lock_pending got=%h exp=0000", pending); end
    tick();
    #1;
    checks++; if (accept !== 1'b0) begin errors++; $display("FAIL lock_accept_end got=%b exp=0", accept); end
  endtask

  task automatic test_set_clear_conflict();
    logic [NM-1:0] seen;
    do_split(4'd4);
    #1;
    checks++; if (pending !== 16'h0010) begin errors++; $display("FAIL conf_pending got=%h exp=0010", pending); end
    busy = 1'b0;
    tick();
    drive_vap(4'd4, 1'b0);
    busy = 1'b1;
    #1;
    checks++; if (bus_if.HSPLITx !== 16'h0) begin errors++; $display("FAIL conf_suppress got=%h exp=0000", bus_if.HSPLITx); end
    tick();
    drive_idle();
    #1;
    checks++; if (pending !== 16'h0010) begin errors++; $display("FAIL conf_setwins got=%h exp=0010", pending); end
    checks++; if (bus_if.HRESP !== 2'd3) begin errors++; $display("FAIL conf_split got=%0d exp=3", bus_if.HRESP); end
    tick();
    tick();
    busy = 1'b0;
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus_if.HSPLITx !== 16'h0 && seen === 16'h0) seen = bus_if.HSPLITx;
      tick();
    end
    checks++; if (seen !== 16'h0010) begin errors++; $display("FAIL conf_release got=%h exp=0010", seen); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL conf_drained got=%h exp=0000", pending); end
  endtask

  task automatic test_reset_mid();
    do_split(4'd0);
    drive_vap(4'd8, 1'b0);
    tick();
    drive_idle();
    #1;
    checks++; if (pending !== 16'h0101) begin errors++; $display("FAIL mid_pending got=%h exp=0101", pending); end
    checks++; if (bus_if.HREADYOUT !== 1'b0) begin errors++; $display("FAIL mid_split1 got=%b exp=0", bus_if.HREADYOUT); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.HREADYOUT !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", bus_if.HREADYOUT); end
    checks++; if (bus_if.HRESP !== 2'd0) begin errors++; $display("FAIL mid_rst_hresp got=%0d exp=0", bus_if.HRESP); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL mid_rst_pending got=%h exp=0000", pending); end
    checks++; if (accept !== 1'b0) begin errors++; $display("FAIL mid_rst_accept got=%b exp=0", accept); end
    tick();
    tick();
    rst_n = 1'b1;
    busy  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (bus_if.HSPLITx !== 16'h0) begin errors++; $display("FAIL mid_no_release%0d got=%h exp=0000", c, bus_if.HSPLITx); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_split_release();
    test_rr_order();
    test_locked();
    test_set_clear_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
